// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter and flush sequencer between WB and the CSR block.
// Picks one cause per WB instruction, pulses it to CSR, then redirects fetch.
module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_inst_pc,
  input  logic [4:0]  wb_exc_flags,
  input  logic        wb_ertn,
  input  logic [31:0] wb_mem_vaddr,
  input  logic [12:0] int_pending,
  input  logic        crmd_ie,
  input  logic [31:0] ex_entry,
  input  logic        redirect_ready,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        wb_commit_en,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        int_req_q, int_req_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        event_s;

  assign redirect_pc = redirect_pc_q;

  // State, redirect target and interrupt sample registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      int_req_q     <= 1'b0;
      redirect_pc_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      int_req_q     <= int_req_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Cause arbitration, CSR pulse outputs and next-state logic
  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    int_req_d      = crmd_ie & (|int_pending);
    event_s        = 1'b0;
    wb_ex          = 1'b0;
    ertn_flush     = 1'b0;
    wb_ecode       = 6'h00;
    wb_esubcode    = 9'h000;
    wb_pc          = 32'h0000_0000;
    wb_vaddr       = 32'h0000_0000;
    wb_commit_en   = 1'b0;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Event outputs are suppressed while reset is held so CSR sees no stray pulse
        if (!reset) begin
          wb_pc    = wb_inst_pc;
          wb_vaddr = wb_inst_pc;
          if (wb_valid) begin
            if (int_req_q) begin
              wb_ex    = 1'b1;
              wb_ecode = ECODE_INT;
            end else if (wb_exc_flags[0]) begin
              wb_ex    = 1'b1;
              wb_ecode = ECODE_ADEF;
            end else if (wb_exc_flags[1]) begin
              wb_ex    = 1'b1;
              wb_ecode = ECODE_INE;
            end else if (wb_exc_flags[2]) begin
              wb_ex    = 1'b1;
              wb_ecode = ECODE_SYS;
            end else if (wb_exc_flags[3]) begin
              wb_ex    = 1'b1;
              wb_ecode = ECODE_BRK;
            end else if (wb_exc_flags[4]) begin
              wb_ex    = 1'b1;
              wb_ecode = ECODE_ALE;
              wb_vaddr = wb_mem_vaddr;
            end else if (wb_ertn) begin
              ertn_flush = 1'b1;
            end else begin
              wb_commit_en = 1'b1;
            end
          end else begin
            wb_commit_en = 1'b0;
          end
        end else begin
          wb_pc = 32'h0000_0000;
        end
        event_s    = wb_ex | ertn_flush;
        pipe_flush = event_s;
        if (event_s) begin
          state_d       = ST_REDIR;
          redirect_pc_d = ex_entry;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIR: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A taken exception consumes the pending interrupt sample
    if (wb_ex) begin
      int_req_d = 1'b0;
    end else begin
      int_req_d = crmd_ie & (|int_pending);
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_inst_pc = 32'h0;
  logic [4:0]  wb_exc_flags = 5'h0;
  logic        wb_ertn = 1'b0;
  logic [31:0] wb_mem_vaddr = 32'h0;
  logic [12:0] int_pending = 13'h0;
  logic        crmd_ie = 1'b0;
  logic [31:0] ex_entry = 32'h0;
  logic        redirect_ready = 1'b0;
  logic        wb_ex, ertn_flush, wb_commit_en, pipe_flush, redirect_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, redirect_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_inst_pc(wb_inst_pc),
    .wb_exc_flags(wb_exc_flags), .wb_ertn(wb_ertn), .wb_mem_vaddr(wb_mem_vaddr),
    .int_pending(int_pending), .crmd_ie(crmd_ie), .ex_entry(ex_entry),
    .redirect_ready(redirect_ready), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_commit_en(wb_commit_en), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: busy while a redirect is outstanding, plus last target
  localparam logic [5:0] CODES [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
  bit          m_busy = 1'b0;
  bit          m_intreq = 1'b0;
  logic [31:0] m_target = 32'h0;
  bit          started = 1'b0;

  function automatic void predict(output bit ev, output bit ex, output bit er,
                                  output logic [5:0] ec, output logic [31:0] va);
    ev = 1'b0; ex = 1'b0; er = 1'b0; ec = 6'h00; va = wb_inst_pc;
    if (reset || m_busy || !wb_valid) return;
    if (m_intreq) begin
      ex = 1'b1;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!ex && wb_exc_flags[i]) begin
          ex = 1'b1;
          ec = CODES[i];
          if (i == 4) va = wb_mem_vaddr;
        end
      end
    end
    er = !ex && wb_ertn;
    ev = ex || er;
  endfunction

  // Model update on the active edge
  always @(posedge clk) begin
    bit ev, ex, er;
    logic [5:0] ec;
    logic [31:0] va;
    predict(ev, ex, er, ec, va);
    started <= 1'b1;
    if (reset) begin
      m_busy   <= 1'b0;
      m_target <= 32'h0;
      m_intreq <= 1'b0;
    end else begin
      if (!m_busy && ev) begin
        m_busy   <= 1'b1;
        m_target <= ex_entry;
      end else if (m_busy && redirect_ready) begin
        m_busy <= 1'b0;
      end
      m_intreq <= ex ? 1'b0 : (crmd_ie && (|int_pending));
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit ev, ex, er;
    logic [5:0] ec;
    logic [31:0] va;
    if (started) begin
      predict(ev, ex, er, ec, va);
      chk("m_wb_ex", wb_ex, ex);
      chk("m_ertn_flush", ertn_flush, er);
      chk("m_ecode", wb_ecode, ec);
      chk("m_esubcode", wb_esubcode, 32'h0);
      if (ev) begin
        chk("m_wb_pc", wb_pc, wb_inst_pc);
        chk("m_wb_vaddr", wb_vaddr, va);
      end
      chk("m_pipe_flush", pipe_flush, ev || m_busy);
      chk("m_redirect_valid", redirect_valid, m_busy);
      chk("m_commit_en", wb_commit_en, wb_valid && !reset && !m_busy && !ev);
      chk("m_redirect_pc", redirect_pc, m_target);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [4:0] fl,
                     input logic er, input logic [31:0] va, input logic [12:0] ip,
                     input logic ie, input logic [31:0] en, input logic rdy);
    @(posedge clk);
    #1;
    wb_valid = v; wb_inst_pc = pc; wb_exc_flags = fl; wb_ertn = er;
    wb_mem_vaddr = va; int_pending = ip; crmd_ie = ie; ex_entry = en;
    redirect_ready = rdy;
    #2;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 13'h0, 1'b0, 32'h0, rdy);
  endtask

  int n_ex, n_rv, n_fl;

  initial begin
    // Reset state
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("rst_wb_ex", wb_ex, 32'h0);
    chk("rst_redirect_valid", redirect_valid, 32'h0);
    chk("rst_pipe_flush", pipe_flush, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_commit", wb_commit_en, 32'h0);
    reset = 1'b0;
    idle(1'b1);

    // SYS with three cycles of backpressure
    cyc(1'b1, 32'h1C00_0100, 5'h04, 1'b0, 32'h0, 13'h0, 1'b0, 32'h1C00_8000, 1'b0);
    chk("sys_wb_ex", wb_ex, 32'h1);
    chk("sys_ecode", wb_ecode, 32'h0B);
    chk("sys_wb_pc", wb_pc, 32'h1C00_0100);
    n_ex = int'(wb_ex); n_rv = int'(redirect_valid); n_fl = int'(pipe_flush);
    for (int k = 0; k < 5; k++) begin
      idle(k == 3);
      if (k < 4) chk("sys_redirect_pc", redirect_pc, 32'h1C00_8000);
      n_ex += int'(wb_ex); n_rv += int'(redirect_valid); n_fl += int'(pipe_flush);
    end
    chk("sys_ex_cycles", n_ex, 32'd1);
    chk("sys_rv_cycles", n_rv, 32'd4);
    chk("sys_flush_cycles", n_fl, 32'd5);

    // ALE vs ADEF
    cyc(1'b1, 32'h1C00_0010, 5'h10, 1'b0, 32'h0000_0003, 13'h0, 1'b0, 32'h1C00_8000, 1'b1);
    chk("ale_ecode", wb_ecode, 32'h09);
    chk("ale_vaddr", wb_vaddr, 32'h0000_0003);
    idle(1'b1);
    cyc(1'b1, 32'h1C00_0002, 5'h01, 1'b0, 32'h0000_0003, 13'h0, 1'b0, 32'h1C00_8000, 1'b1);
    chk("adef_ecode", wb_ecode, 32'h08);
    chk("adef_esub", wb_esubcode, 32'h0);
    chk("adef_vaddr", wb_vaddr, 32'h1C00_0002);
    idle(1'b1);

    // Interrupt beats INE+BRK
    cyc(1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 13'h800, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h1C00_0200, 5'h0A, 1'b0, 32'h0, 13'h800, 1'b1, 32'h1C00_9000, 1'b1);
    chk("int_wb_ex", wb_ex, 32'h1);
    chk("int_ecode", wb_ecode, 32'h00);
    chk("int_commit", wb_commit_en, 32'h0);
    idle(1'b1);
    cyc(1'b1, 32'h1C00_0204, 5'h0, 1'b0, 32'h0, 13'h0, 1'b0, 32'h0, 1'b1);
    chk("int_after_commit", wb_commit_en, 32'h1);
    chk("int_after_wb_ex", wb_ex, 32'h0);

    // ERTN, then ERTN with INE
    cyc(1'b1, 32'h1C00_0300, 5'h0, 1'b1, 32'h0, 13'h0, 1'b0, 32'h1C00_0104, 1'b0);
    chk("ertn_flush", ertn_flush, 32'h1);
    chk("ertn_wb_ex", wb_ex, 32'h0);
    chk("ertn_commit", wb_commit_en, 32'h0);
    idle(1'b1);
    chk("ertn_redirect_valid", redirect_valid, 32'h1);
    chk("ertn_redirect_pc", redirect_pc, 32'h1C00_0104);
    cyc(1'b1, 32'h1C00_0400, 5'h02, 1'b1, 32'h0, 13'h0, 1'b0, 32'h1C00_8000, 1'b1);
    chk("ertn_ine_wb_ex", wb_ex, 32'h1);
    chk("ertn_ine_ecode", wb_ecode, 32'h0D);
    chk("ertn_ine_flush", ertn_flush, 32'h0);
    idle(1'b1);

    // BRK during REDIR is ignored
    cyc(1'b1, 32'h1C00_0500, 5'h04, 1'b0, 32'h0, 13'h0, 1'b0, 32'h1C00_8000, 1'b0);
    cyc(1'b1, 32'h1C00_0504, 5'h08, 1'b0, 32'h0, 13'h0, 1'b0, 32'h1C00_7000, 1'b0);
    chk("mask_wb_ex", wb_ex, 32'h0);
    chk("mask_commit", wb_commit_en, 32'h0);
    idle(1'b1);
    chk("mask_redirect_pc", redirect_pc, 32'h1C00_8000);
    cyc(1'b1, 32'h1C00_0600, 5'h0, 1'b0, 32'h0, 13'h0, 1'b0, 32'h0, 1'b1);
    chk("mask_after_commit", wb_commit_en, 32'h1);

    // Reset for two cycles in the middle of a redirect
    cyc(1'b1, 32'h1C00_0700, 5'h04, 1'b0, 32'h0, 13'h0, 1'b0, 32'h1C00_8000, 1'b0);
    idle(1'b0);
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("rstr_redirect_valid", redirect_valid, 32'h0);
    chk("rstr_pipe_flush", pipe_flush, 32'h0);
    chk("rstr_redirect_pc", redirect_pc, 32'h0);
    chk("rstr_wb_ex", wb_ex, 32'h0);
    reset = 1'b0;
    cyc(1'b1, 32'h1C00_0800, 5'h04, 1'b0, 32'h0, 13'h0, 1'b0, 32'h1C00_8800, 1'b1);
    chk("rstr_sys_wb_ex", wb_ex, 32'h1);
    chk("rstr_sys_ecode", wb_ecode, 32'h0B);
    idle(1'b1);
    chk("rstr_sys_redirect_pc", redirect_pc, 32'h1C00_8800);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 3) != 0, $urandom,
          ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0,
          $urandom_range(0, 7) == 0, $urandom,
          ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'h0,
          1'($urandom), $urandom, 1'($urandom));
    end
    reset = 1'b0;
    idle(1'b1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
